// File: rtl/mem_stage_if.sv
// Bundle of EX->MEM, data-bus response and MEM->WB signals around mem_stage.
// slave is the stage's own view; master is the surrounding pipeline's view.
interface mem_stage_if #(
  parameter int SIDE_W = 48
);
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic [4:0]        es_dest;
  logic [3:0]        es_gr_strb;
  logic [31:0]       es_alu_result;
  logic [2:0]        es_load_op;
  logic              es_mem_req;
  logic              es_ex;
  logic [4:0]        es_excode;
  logic [31:0]       es_badvaddr;
  logic [SIDE_W-1:0] es_side;
  logic              es_killed_pending;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              ws_allowin;
  logic              ws_do_flush;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic [4:0]        ms_dest;
  logic [3:0]        ms_gr_strb;
  logic [31:0]       ms_final_result;
  logic              ms_ex;
  logic [4:0]        ms_excode;
  logic [31:0]       ms_badvaddr;
  logic [SIDE_W-1:0] ms_side;
  logic [4:0]        ms_rf_dest;
  logic              ms_res_ready;
  logic              ms_ex_block;

  modport slave (
    input  es_to_ms_valid, es_pc, es_dest, es_gr_strb, es_alu_result, es_load_op,
           es_mem_req, es_ex, es_excode, es_badvaddr, es_side, es_killed_pending,
           data_data_ok, data_rdata, ws_allowin, ws_do_flush,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_strb, ms_final_result,
           ms_ex, ms_excode, ms_badvaddr, ms_side, ms_rf_dest, ms_res_ready, ms_ex_block
  );

  modport master (
    output es_to_ms_valid, es_pc, es_dest, es_gr_strb, es_alu_result, es_load_op,
           es_mem_req, es_ex, es_excode, es_badvaddr, es_side, es_killed_pending,
           data_data_ok, data_rdata, ws_allowin, ws_do_flush,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_strb, ms_final_result,
           ms_ex, ms_excode, ms_badvaddr, ms_side, ms_rf_dest, ms_res_ready, ms_ex_block
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: 1 cycle for ALU ops, loads/stores complete on data_ok (>=1 cycle);
// stalls EX via ms_allowin while a response is owed or WB stalls; drops responses of flushed ops.
module mem_stage #(
  parameter int SIDE_W = 48
) (
  input logic         clk,
  input logic         reset,
  mem_stage_if.slave  bus
);
  logic              ms_valid;
  logic              ms_wait;
  logic              buf_valid;
  logic [31:0]       buf_data;
  logic [1:0]        drop_cnt;
  logic [31:0]       pc_q;
  logic [4:0]        dest_q;
  logic [3:0]        gr_strb_q;
  logic [31:0]       alu_q;
  logic [2:0]        load_op_q;
  logic              ex_q;
  logic [4:0]        excode_q;
  logic [31:0]       badvaddr_q;
  logic [SIDE_W-1:0] side_q;

  logic        drop_hit;
  logic        resp_ok;
  logic        ready_go;
  logic        allowin;
  logic        capture;
  logic [1:0]  drop_next;
  logic [31:0] load_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] final_result;

  assign drop_hit = bus.data_data_ok && (drop_cnt != 2'd0);
  assign resp_ok  = bus.data_data_ok && (drop_cnt == 2'd0);
  assign ready_go = !ms_wait || resp_ok;
  assign allowin  = !ms_valid || (ready_go && bus.ws_allowin);
  assign capture  = bus.es_to_ms_valid && allowin && !bus.ws_do_flush;

  // A response eaten by a pending drop still leaves the killed op's own response owed.
  always_comb begin
    drop_next = drop_cnt - {1'b0, drop_hit};
    if (bus.ws_do_flush) begin
      drop_next = drop_next + {1'b0, ms_wait && !resp_ok} + {1'b0, bus.es_killed_pending};
    end
  end

  always_comb begin
    load_word = buf_valid ? buf_data : bus.data_rdata;
    case (alu_q[1:0])
      2'd0:    ld_byte = load_word[7:0];
      2'd1:    ld_byte = load_word[15:8];
      2'd2:    ld_byte = load_word[23:16];
      default: ld_byte = load_word[31:24];
    endcase
    ld_half = alu_q[1] ? load_word[31:16] : load_word[15:0];
    case (load_op_q)
      3'd1:    final_result = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    final_result = {24'd0, ld_byte};
      3'd3:    final_result = {{16{ld_half[15]}}, ld_half};
      3'd4:    final_result = {16'd0, ld_half};
      3'd5:    final_result = load_word;
      default: final_result = alu_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid  <= 1'b0;
      ms_wait   <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= 32'd0;
      drop_cnt  <= 2'd0;
    end else begin
      drop_cnt <= drop_next;
      if (bus.ws_do_flush) begin
        ms_valid  <= 1'b0;
        ms_wait   <= 1'b0;
        buf_valid <= 1'b0;
      end else if (allowin) begin
        ms_valid  <= bus.es_to_ms_valid;
        ms_wait   <= bus.es_to_ms_valid && bus.es_mem_req && !bus.es_ex;
        buf_valid <= 1'b0;
      end else if (resp_ok && ms_wait) begin
        // Response arrived while WB is stalled: hold it until the transfer.
        ms_wait   <= 1'b0;
        buf_valid <= 1'b1;
        buf_data  <= bus.data_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= 32'd0;
      dest_q     <= 5'd0;
      gr_strb_q  <= 4'd0;
      alu_q      <= 32'd0;
      load_op_q  <= 3'd0;
      ex_q       <= 1'b0;
      excode_q   <= 5'd0;
      badvaddr_q <= 32'd0;
      side_q     <= '0;
    end else if (capture) begin
      pc_q       <= bus.es_pc;
      dest_q     <= bus.es_dest;
      gr_strb_q  <= bus.es_gr_strb;
      alu_q      <= bus.es_alu_result;
      load_op_q  <= bus.es_load_op;
      ex_q       <= bus.es_ex;
      excode_q   <= bus.es_excode;
      badvaddr_q <= bus.es_badvaddr;
      side_q     <= bus.es_side;
    end
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = ms_valid && ready_go && !bus.ws_do_flush;
  assign bus.ms_pc           = pc_q;
  assign bus.ms_dest         = dest_q;
  assign bus.ms_gr_strb      = gr_strb_q;
  assign bus.ms_final_result = final_result;
  assign bus.ms_ex           = ex_q;
  assign bus.ms_excode       = excode_q;
  assign bus.ms_badvaddr     = badvaddr_q;
  assign bus.ms_side         = side_q;
  assign bus.ms_rf_dest      = ms_valid ? dest_q : 5'd0;
  assign bus.ms_res_ready    = ms_valid && ready_go;
  assign bus.ms_ex_block     = ms_valid && ex_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage plus hand sequences for exception and async reset.
module tb_mem_stage;
  localparam int SIDE_W = 48;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if #(.SIDE_W(SIDE_W)) bus();
  mem_stage #(.SIDE_W(SIDE_W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    string       name;
    logic        ev;
    logic [2:0]  op;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        req, kp, dok;
    logic [31:0] rd;
    logic        wsa, fl;
    logic        e_alw, e_tov, e_rr;
    logic [4:0]  e_rfd;
    logic        chk;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  int m_drop = 0;
  int m_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int ev, input int op, input logic [31:0] alu,
                     input int dest, input int req, input int kp, input int dok,
                     input logic [31:0] rd, input int wsa, input int fl,
                     input int e_alw, input int e_tov, input int e_rr, input int e_rfd,
                     input int chk, input logic [31:0] e_res);
    vec_t v;
    v.name = n; v.ev = (ev != 0); v.op = 3'(op); v.alu = alu; v.dest = 5'(dest);
    v.req = (req != 0); v.kp = (kp != 0); v.dok = (dok != 0); v.rd = rd;
    v.wsa = (wsa != 0); v.fl = (fl != 0);
    v.e_alw = (e_alw != 0); v.e_tov = (e_tov != 0); v.e_rr = (e_rr != 0);
    v.e_rfd = 5'(e_rfd); v.chk = (chk != 0); v.e_res = e_res;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    bus.es_to_ms_valid = 1'b0; bus.es_pc = 32'hBFC0_0000; bus.es_dest = 5'd0;
    bus.es_gr_strb = 4'hF; bus.es_alu_result = 32'd0; bus.es_load_op = 3'd0;
    bus.es_mem_req = 1'b0; bus.es_ex = 1'b0; bus.es_excode = 5'd0;
    bus.es_badvaddr = 32'd0; bus.es_side = '0; bus.es_killed_pending = 1'b0;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0; bus.ws_allowin = 1'b1;
    bus.ws_do_flush = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    idle_inputs();
    bus.es_to_ms_valid = v.ev; bus.es_load_op = v.op; bus.es_alu_result = v.alu;
    bus.es_dest = v.dest; bus.es_mem_req = v.req; bus.es_killed_pending = v.kp;
    bus.data_data_ok = v.dok; bus.data_rdata = v.rd; bus.ws_allowin = v.wsa;
    bus.ws_do_flush = v.fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name          ev op alu            d  rq kp ok rdata          wsa fl  alw tov rr rfd chk res
    add("idle",         0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 1, 0);
    add("alu1_cap",     1, 0, 32'h11,       3, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 1, 0);
    add("alu2_cap",     1, 0, 32'h22,       4, 0, 0, 0, 0,             1, 0,  1, 1, 1,  3, 1, 32'h11);
    add("alu2_out",     0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 1, 1,  4, 1, 32'h22);
    add("alu_empty",    0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lb_cap",       1, 1, 32'h1003,     5, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lb_resp",      0, 0, 0,            0, 0, 0, 1, 32'h80FF_1234, 1, 0,  1, 1, 1,  5, 1, 32'hFFFF_FF80);
    add("lhu_cap",      1, 4, 32'h2002,     6, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lhu_resp",     0, 0, 0,            0, 0, 0, 1, 32'h80FF_1234, 1, 0,  1, 1, 1,  6, 1, 32'h0000_80FF);
    add("lh_cap",       1, 3, 32'h3000,     7, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lh_resp",      0, 0, 0,            0, 0, 0, 1, 32'h1234_8001, 1, 0,  1, 1, 1,  7, 1, 32'hFFFF_8001);
    add("lbu_cap",      1, 2, 32'h4001,     8, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lbu_resp",     0, 0, 0,            0, 0, 0, 1, 32'h80FF_E234, 1, 0,  1, 1, 1,  8, 1, 32'h0000_00E2);
    add("idle2",        0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lw_cap",       1, 5, 32'h5000,     9, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("lw_wait1",     0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  0, 0, 0,  9, 0, 0);
    add("lw_wait2",     0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  0, 0, 0,  9, 0, 0);
    add("lw_wait3",     0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  0, 0, 0,  9, 0, 0);
    add("lw_resp_stl",  0, 0, 0,            0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0,  0, 1, 1,  9, 1, 32'hDEAD_BEEF);
    add("lw_buf_stl",   0, 0, 0,            0, 0, 0, 0, 0,             0, 0,  0, 1, 1,  9, 1, 32'hDEAD_BEEF);
    add("lw_buf_out",   0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 1, 1,  9, 1, 32'hDEAD_BEEF);
    add("idle3",        0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("fl_cap",       1, 5, 32'h6000,    10, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("fl_kill",      0, 0, 0,            0, 0, 1, 0, 0,             1, 1,  0, 0, 0, 10, 0, 0);
    add("drop1_cap",    1, 5, 32'h7000,    11, 1, 0, 1, 32'hBAD0_0001, 1, 0,  1, 0, 0,  0, 0, 0);
    add("drop2",        0, 0, 0,            0, 0, 0, 1, 32'hBAD0_0002, 1, 0,  0, 0, 0, 11, 0, 0);
    add("lw2_wait",     0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  0, 0, 0, 11, 0, 0);
    add("lw2_resp",     0, 0, 0,            0, 0, 0, 1, 32'h1234_5678, 1, 0,  1, 1, 1, 11, 1, 32'h1234_5678);
    add("idle4",        0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("flok_cap",     1, 5, 32'h8000,    12, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("flok_kill",    0, 0, 0,            0, 0, 0, 1, 32'hBAD0_BAD0, 1, 1,  1, 0, 1, 12, 0, 0);
    add("flok_next",    1, 5, 32'h9000,    13, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("flok_resp",    0, 0, 0,            0, 0, 0, 1, 32'h0BAD_F00D, 1, 0,  1, 1, 1, 13, 1, 32'h0BAD_F00D);
    add("idle5",        0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("st_cap",       1, 0, 32'hB004,     0, 1, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);
    add("st_wait",      0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  0, 0, 0,  0, 0, 0);
    add("st_ack",       0, 0, 0,            0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0,  1, 1, 1,  0, 1, 32'h0000_B004);
    add("idle6",        0, 0, 0,            0, 0, 0, 0, 0,             1, 0,  1, 0, 0,  0, 0, 0);

    reset = 1'b1;
    idle_inputs();
    step();
    step();
    check("rst.allowin",  64'(bus.ms_allowin), 64'd1);
    check("rst.to_ws",    64'(bus.ms_to_ws_valid), 64'd0);
    check("rst.result",   64'(bus.ms_final_result), 64'd0);
    check("rst.ex_block", 64'(bus.ms_ex_block), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      bit   dropped;
      v = vecs[i];
      step();
      apply(v);
      @(negedge clk);
      check({v.name, ".allowin"},   64'(bus.ms_allowin),     64'(v.e_alw));
      check({v.name, ".to_ws"},     64'(bus.ms_to_ws_valid), 64'(v.e_tov));
      check({v.name, ".res_ready"}, 64'(bus.ms_res_ready),   64'(v.e_rr));
      check({v.name, ".rf_dest"},   64'(bus.ms_rf_dest),     64'(v.e_rfd));
      if (v.chk) check({v.name, ".result"}, 64'(bus.ms_final_result), 64'(v.e_res));
      // Track owed/dropped responses to catch drop-count overflow in the stimulus.
      dropped = v.dok && (m_drop > 0);
      if (dropped) m_drop--;
      if (v.fl) begin
        m_drop += ((m_wait != 0) && !(v.dok && !dropped)) ? 1 : 0;
        m_drop += v.kp ? 1 : 0;
        m_wait = 0;
        checks++;
        if (m_drop > 3) begin
          errors++;
          $display("FAIL %s.drop_overflow: got %0d required <= 3", v.name, m_drop);
        end
      end else begin
        if (v.dok && !dropped) m_wait = 0;
        if (v.ev && v.e_alw) m_wait = (v.req) ? 1 : 0;
      end
    end

    // Exception on a load: no response owed, fields pass through in one cycle.
    step();
    idle_inputs();
    bus.es_to_ms_valid = 1'b1; bus.es_load_op = 3'd5; bus.es_mem_req = 1'b1;
    bus.es_ex = 1'b1; bus.es_excode = 5'h04; bus.es_badvaddr = 32'h0000_A003;
    bus.es_pc = 32'hBFC0_0100; bus.es_side = 48'h1234_5678_9ABC; bus.es_dest = 5'd14;
    bus.es_alu_result = 32'h0000_A003;
    @(negedge clk);
    check("ex.cap_allowin", 64'(bus.ms_allowin), 64'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("ex.to_ws",    64'(bus.ms_to_ws_valid), 64'd1);
    check("ex.ex_block", 64'(bus.ms_ex_block), 64'd1);
    check("ex.ex",       64'(bus.ms_ex), 64'd1);
    check("ex.excode",   64'(bus.ms_excode), 64'h04);
    check("ex.badvaddr", 64'(bus.ms_badvaddr), 64'h0000_A003);
    check("ex.pc",       64'(bus.ms_pc), 64'hBFC0_0100);
    check("ex.side",     64'(bus.ms_side), 64'h1234_5678_9ABC);
    check("ex.allowin",  64'(bus.ms_allowin), 64'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("ex.gone_to_ws", 64'(bus.ms_to_ws_valid), 64'd0);
    check("ex.gone_block", 64'(bus.ms_ex_block), 64'd0);

    // Build ms_wait=1 with drop_cnt=1, then reset asynchronously mid-cycle.
    step();
    idle_inputs();
    bus.es_to_ms_valid = 1'b1; bus.es_load_op = 3'd5; bus.es_mem_req = 1'b1;
    bus.es_alu_result = 32'h0000_C000; bus.es_dest = 5'd15;
    step();
    idle_inputs();
    bus.ws_do_flush = 1'b1;
    step();
    idle_inputs();
    bus.es_to_ms_valid = 1'b1; bus.es_load_op = 3'd5; bus.es_mem_req = 1'b1;
    bus.es_alu_result = 32'h0000_C100; bus.es_dest = 5'd16;
    step();
    idle_inputs();
    @(negedge clk);
    check("rw.wait_allowin", 64'(bus.ms_allowin), 64'd0);
    check("rw.wait_rf_dest", 64'(bus.ms_rf_dest), 64'd16);
    #2 reset = 1'b1;
    #1;
    check("rw.to_ws",     64'(bus.ms_to_ws_valid), 64'd0);
    check("rw.allowin",   64'(bus.ms_allowin), 64'd1);
    check("rw.rf_dest",   64'(bus.ms_rf_dest), 64'd0);
    check("rw.result",    64'(bus.ms_final_result), 64'd0);
    check("rw.pc",        64'(bus.ms_pc), 64'd0);
    check("rw.res_ready", 64'(bus.ms_res_ready), 64'd0);
    check("rw.side",      64'(bus.ms_side), 64'd0);
    #1 reset = 1'b0;
    step();
    idle_inputs();
    bus.es_to_ms_valid = 1'b1; bus.es_load_op = 3'd5; bus.es_mem_req = 1'b1;
    bus.es_alu_result = 32'h0000_D000; bus.es_dest = 5'd17;
    @(negedge clk);
    check("rw.cap_allowin", 64'(bus.ms_allowin), 64'd1);
    step();
    idle_inputs();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check("rw.resp_to_ws",  64'(bus.ms_to_ws_valid), 64'd1);
    check("rw.resp_result", 64'(bus.ms_final_result), 64'h5555_AAAA);
    check("rw.resp_rfdest", 64'(bus.ms_rf_dest), 64'd17);
    step();
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
